// File: rtl/dcache_wt.sv
// Direct-mapped, write-through, no-write-allocate data cache with 4-word lines.
// Loads hit in the same cycle; misses refill with a 4-beat burst, stores always go to memory.
module dcache_wt #(
  parameter  int LINES = 16,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  input  logic        cpu_rd_i,
  input  logic        cpu_wr_i,
  output logic [31:0] cpu_rdata_o,
  output logic        cpu_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i
);

  localparam int TAG_W = 28 - IDX_W;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_REFILL = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [1:0]       beat_q, beat_d;
  logic [31:2]      addr_q, addr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [31:0]      data_q [LINES][4];

  logic [IDX_W-1:0] idx, a_idx;
  logic [TAG_W-1:0] tag, a_tag;
  logic [1:0]       off, a_off;
  logic             hit, a_hit;
  logic             refill_start, fill_we, wr_upd;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^cpu_addr_i[1:0];

  assign idx   = cpu_addr_i[3+IDX_W:4];
  assign tag   = cpu_addr_i[31:4+IDX_W];
  assign off   = cpu_addr_i[3:2];
  assign hit   = valid_q[idx] && (tag_q[idx] == tag);

  // Latched request; used for the line being refilled or the store in flight.
  assign a_idx = addr_q[3+IDX_W:4];
  assign a_tag = addr_q[31:4+IDX_W];
  assign a_off = addr_q[3:2];
  assign a_hit = valid_q[a_idx] && (tag_q[a_idx] == a_tag);

  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    refill_start = 1'b0;
    fill_we      = 1'b0;
    wr_upd       = 1'b0;
    cpu_stall_o  = 1'b0;
    cpu_rdata_o  = '0;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    case (state_q)
      S_IDLE: begin
        if (cpu_wr_i) begin
          cpu_stall_o = 1'b1;
          addr_d      = cpu_addr_i[31:2];
          wdata_d     = cpu_wdata_i;
          state_d     = S_WRITE;
        end else if (cpu_rd_i) begin
          if (hit) begin
            cpu_rdata_o = data_q[idx][off];
          end else begin
            cpu_stall_o  = 1'b1;
            refill_start = 1'b1;
            addr_d       = {cpu_addr_i[31:4], 2'b00};
            beat_d       = 2'd0;
            state_d      = S_REFILL;
          end
        end
      end
      S_REFILL: begin
        mem_req_o   = 1'b1;
        mem_addr_o  = {addr_q[31:4], beat_q, 2'b00};
        cpu_stall_o = 1'b1;
        if (mem_ack_i) begin
          fill_we = 1'b1;
          beat_d  = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = S_IDLE;
        end
      end
      S_WRITE: begin
        mem_req_o   = 1'b1;
        mem_we_o    = 1'b1;
        mem_addr_o  = {addr_q, 2'b00};
        mem_wdata_o = wdata_q;
        // Release in the ack cycle so the pipeline advances and does not reissue.
        cpu_stall_o = ~mem_ack_i;
        if (mem_ack_i) begin
          wr_upd  = a_hit;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      beat_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      if (refill_start) valid_q[idx] <= 1'b0;
      if (fill_we && (beat_q == 2'd3)) valid_q[a_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (fill_we) begin
        data_q[a_idx][beat_q] <= mem_rdata_i;
        if (beat_q == 2'd3) tag_q[a_idx] <= a_tag;
      end
      if (wr_upd) data_q[a_idx][a_off] <= wdata_q;
    end
  end

endmodule
